hazard_control: RTL

- Pipeline sequencer for the 5-stage RV32 core.
- Generates per-register stall/flush for IF/ID, ID/EXE, EXE/MEM and MEM/WB, plus operand-forwarding selects for the ID stage.
- Resolves data hazards (RAW, load-use), control hazards (taken branch/jump, trap redirect) and wishbone wait states.
- A small FSM drops stale instruction fetches that were in flight when the PC was redirected.

---
 rtl/hazard_control_pkg.sv | 33 +++
 rtl/hazard_control_fwd_unit.sv | 30 +++
 rtl/hazard_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_control_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_control_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RST = 2'b00,
    ST_RUN = 2'b01,
    ST_BRW = 2'b10,
    ST_EXC = 2'b11
  } hc_state_e;

  // add x0, x0, x0 -- what a flushed pipeline register is loaded with
  localparam logic [31:0] NOP_INSN = 32'h0000_0033;

  typedef struct packed {
    logic if_id;
    logic id_exe;
    logic exe_mem;
    logic mem_wb;
  } pipe_ctl_t;

  // True when a live older writer targets a register the ID instruction reads.
  function automatic logic rd_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs,
                                  input logic use_rs);
    return we && use_rs && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_fwd_unit.sv
// Operand bypass select for one ID-stage source register.
module fwd_unit
  import hazard_control_pkg::*;
#(
  parameter bit ENABLE_FORWARDING = 1'b1
) (
  input  logic [4:0] rs_i,
  input  logic       use_rs_i,
  input  logic       force_rf_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_rf_i,
  input  logic       mem_is_load_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_rf_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (ENABLE_FORWARDING && !force_rf_i) begin
      // Load data is not yet in EXE/MEM, so a load there is never bypassed.
      if (rd_hit(mem_rd_i, mem_we_rf_i, rs_i, use_rs_i) && !mem_is_load_i) begin
        sel_o = FWD_EXMEM;
      end else if (rd_hit(wb_rd_i, wb_we_rf_i, rs_i, use_rs_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Pipeline sequencer: stall/flush per pipeline register, ID operand forwarding, and
// a small FSM that discards fetches issued down a redirected path.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter bit ENABLE_FORWARDING = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_we_rf_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_rf_i,
  input  logic       mem_is_load_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_rf_i,
  input  logic       if_busy_i,
  input  logic       mem_busy_i,
  input  logic       br_j_taken_i,
  input  logic       exc_taken_i,
  output logic       if_id_stall_o,
  output logic       id_exe_stall_o,
  output logic       exe_mem_stall_o,
  output logic       mem_wb_stall_o,
  output logic       if_id_flush_o,
  output logic       id_exe_flush_o,
  output logic       exe_mem_flush_o,
  output logic       mem_wb_flush_o,
  output logic [1:0] fwd_sel_a_o,
  output logic [1:0] fwd_sel_b_o
);

  hc_state_e state_q, state_d;
  logic      in_reset;
  logic      ex_hit, mem_hit, wb_hit;
  logic      ld_use, raw_hold;
  pipe_ctl_t stall, flush;

  assign in_reset = rst_i || (state_q == ST_RST);

  assign ex_hit  = rd_hit(ex_rd_i, ex_we_rf_i, id_rs1_i, id_use_rs1_i) ||
                   rd_hit(ex_rd_i, ex_we_rf_i, id_rs2_i, id_use_rs2_i);
  assign mem_hit = rd_hit(mem_rd_i, mem_we_rf_i, id_rs1_i, id_use_rs1_i) ||
                   rd_hit(mem_rd_i, mem_we_rf_i, id_rs2_i, id_use_rs2_i);
  assign wb_hit  = rd_hit(wb_rd_i, wb_we_rf_i, id_rs1_i, id_use_rs1_i) ||
                   rd_hit(wb_rd_i, wb_we_rf_i, id_rs2_i, id_use_rs2_i);

  assign ld_use   = ex_is_load_i && ex_hit;
  // Without bypassing, the consumer waits until every older producer has retired.
  assign raw_hold = ENABLE_FORWARDING ? (mem_is_load_i && mem_hit)
                                      : (ex_hit || mem_hit || wb_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_RUN;
      default: begin
        if (exc_taken_i) begin
          state_d = if_busy_i ? ST_EXC : ST_RUN;
        end else if (br_j_taken_i) begin
          state_d = if_busy_i ? ST_BRW : ST_RUN;
        end else if (!if_busy_i) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    stall = '0;
    flush = '0;
    if (in_reset || exc_taken_i) begin
      flush = '1;
    end else begin
      if (mem_busy_i) begin
        stall.if_id   = 1'b1;
        stall.id_exe  = 1'b1;
        stall.exe_mem = 1'b1;
        flush.mem_wb  = 1'b1;
      end
      if (br_j_taken_i) begin
        flush.if_id  = 1'b1;
        flush.id_exe = 1'b1;
      end else if (!mem_busy_i && (ld_use || raw_hold)) begin
        stall.if_id  = 1'b1;
        flush.id_exe = 1'b1;
      end
      // Fetch bubble, unless ID is being held and must keep its instruction.
      if ((state_q == ST_RUN) && if_busy_i && !stall.if_id) begin
        flush.if_id = 1'b1;
      end
      if ((state_q == ST_BRW) || (state_q == ST_EXC)) begin
        flush.if_id = 1'b1;
      end
      if (state_q == ST_EXC) begin
        flush.id_exe  = 1'b1;
        flush.exe_mem = 1'b1;
      end
    end
  end

  assign if_id_stall_o   = stall.if_id   && !flush.if_id;
  assign id_exe_stall_o  = stall.id_exe  && !flush.id_exe;
  assign exe_mem_stall_o = stall.exe_mem && !flush.exe_mem;
  assign mem_wb_stall_o  = stall.mem_wb  && !flush.mem_wb;
  assign if_id_flush_o   = flush.if_id;
  assign id_exe_flush_o  = flush.id_exe;
  assign exe_mem_flush_o = flush.exe_mem;
  assign mem_wb_flush_o  = flush.mem_wb;

  fwd_unit #(
    .ENABLE_FORWARDING(ENABLE_FORWARDING)
  ) u_fwd_a (
    .rs_i         (id_rs1_i),
    .use_rs_i     (id_use_rs1_i),
    .force_rf_i   (in_reset),
    .mem_rd_i     (mem_rd_i),
    .mem_we_rf_i  (mem_we_rf_i),
    .mem_is_load_i(mem_is_load_i),
    .wb_rd_i      (wb_rd_i),
    .wb_we_rf_i   (wb_we_rf_i),
    .sel_o        (fwd_sel_a_o)
  );

  fwd_unit #(
    .ENABLE_FORWARDING(ENABLE_FORWARDING)
  ) u_fwd_b (
    .rs_i         (id_rs2_i),
    .use_rs_i     (id_use_rs2_i),
    .force_rf_i   (in_reset),
    .mem_rd_i     (mem_rd_i),
    .mem_we_rf_i  (mem_we_rf_i),
    .mem_is_load_i(mem_is_load_i),
    .wb_rd_i      (wb_rd_i),
    .wb_we_rf_i   (wb_we_rf_i),
    .sel_o        (fwd_sel_b_o)
  );

endmodule
